// File: rtl/axi4lite_ram_slave.sv
// AXI4-Lite RAM responder: word-organised storage with independent read/write FSMs and wait states.
// Build option AXIRAM_UNALIGNED_ERR_EN: word-misaligned AW/AR addresses return SLVERR.
module axi4lite_ram_slave #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_WORDS  = 1024,
    parameter int RD_LATENCY = 2,
    parameter int WR_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(MEM_WORDS);
    localparam int HI_LSB = OFF_W + IDX_W;

    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rstate_t;

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    wstate_t               wstate;
    rstate_t               rstate;
    logic                  aw_captured, w_captured;
    logic [ADDR_WIDTH-1:0] awaddr_q, araddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]     wstrb_q;
    logic [3:0]            wcnt, rcnt;
    logic                  aw_hs, w_hs, ar_hs;
    logic                  wr_err, rd_err, wr_commit;
    logic [IDX_W-1:0]      wr_idx, rd_idx;

    assign aw_hs  = s_axi_awvalid && s_axi_awready;
    assign w_hs   = s_axi_wvalid && s_axi_wready;
    assign ar_hs  = s_axi_arvalid && s_axi_arready;
    assign wr_idx = awaddr_q[OFF_W +: IDX_W];
    assign rd_idx = araddr_q[OFF_W +: IDX_W];

`ifdef AXIRAM_UNALIGNED_ERR_EN
    assign wr_err = (|awaddr_q[ADDR_WIDTH-1:HI_LSB]) || (|awaddr_q[OFF_W-1:0]);
    assign rd_err = (|araddr_q[ADDR_WIDTH-1:HI_LSB]) || (|araddr_q[OFF_W-1:0]);
`else
    assign wr_err = |awaddr_q[ADDR_WIDTH-1:HI_LSB];
    assign rd_err = |araddr_q[ADDR_WIDTH-1:HI_LSB];
    // byte offsets select nothing when misalignment is tolerated
    logic unused_offsets;
    assign unused_offsets = ^{awaddr_q[OFF_W-1:0], araddr_q[OFF_W-1:0]};
`endif

    assign wr_commit = (wstate == W_WAIT) && (wcnt == 4'd0) && !wr_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            wstate        <= W_IDLE;
            aw_captured   <= 1'b0;
            w_captured    <= 1'b0;
            wcnt          <= 4'd0;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= 2'b00;
        end else begin
            case (wstate)
                W_IDLE: begin
                    if (aw_hs) begin
                        awaddr_q    <= s_axi_awaddr;
                        aw_captured <= 1'b1;
                    end
                    if (w_hs) begin
                        wdata_q    <= s_axi_wdata;
                        wstrb_q    <= s_axi_wstrb;
                        w_captured <= 1'b1;
                    end
                    if ((aw_captured || aw_hs) && (w_captured || w_hs)) begin
                        wstate        <= W_WAIT;
                        wcnt          <= 4'(WR_LATENCY);
                        s_axi_awready <= 1'b0;
                        s_axi_wready  <= 1'b0;
                    end else begin
                        s_axi_awready <= !(aw_captured || aw_hs);
                        s_axi_wready  <= !(w_captured || w_hs);
                    end
                end
                W_WAIT: begin
                    if (wcnt == 4'd0) begin
                        s_axi_bvalid <= 1'b1;
                        s_axi_bresp  <= wr_err ? 2'b10 : 2'b00;
                        wstate       <= W_RESP;
                    end else begin
                        wcnt <= wcnt - 4'd1;
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        s_axi_bvalid  <= 1'b0;
                        aw_captured   <= 1'b0;
                        w_captured    <= 1'b0;
                        s_axi_awready <= 1'b1;
                        s_axi_wready  <= 1'b1;
                        wstate        <= W_IDLE;
                    end
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end

    // read loads on the same edge as a commit see the old word
    always_ff @(posedge clk) begin
        if (rst) begin
            rstate        <= R_IDLE;
            rcnt          <= 4'd0;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rresp   <= 2'b00;
            s_axi_rdata   <= '0;
        end else begin
            case (rstate)
                R_IDLE: begin
                    if (ar_hs) begin
                        araddr_q      <= s_axi_araddr;
                        rcnt          <= 4'(RD_LATENCY);
                        s_axi_arready <= 1'b0;
                        rstate        <= R_WAIT;
                    end else begin
                        s_axi_arready <= 1'b1;
                    end
                end
                R_WAIT: begin
                    if (rcnt == 4'd0) begin
                        s_axi_rdata  <= rd_err ? '0 : mem[rd_idx];
                        s_axi_rresp  <= rd_err ? 2'b10 : 2'b00;
                        s_axi_rvalid <= 1'b1;
                        rstate       <= R_RESP;
                    end else begin
                        rcnt <= rcnt - 4'd1;
                    end
                end
                R_RESP: begin
                    if (s_axi_rready) begin
                        s_axi_rvalid  <= 1'b0;
                        s_axi_arready <= 1'b1;
                        rstate        <= R_IDLE;
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_commit) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (wstrb_q[i]) mem[wr_idx][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
    end
endmodule
